// File: rtl/seq_playback_ctrl.sv
// Playback sequencer for the Sequence Memory Game: steps through a stored colour
// pattern, lighting each symbol for ON_TICKS slow ticks then a dark OFF_TICKS gap.
module seq_playback_ctrl #(
  parameter int TICK_DIV  = 25000000,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 1,
  parameter int AW        = 4,
  parameter int SYM_W     = 2
) (
  input  logic                  cin,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [AW:0]           len,
  output logic [AW-1:0]         sym_addr,
  input  logic [SYM_W-1:0]      sym_data,
  output logic [2**SYM_W-1:0]   led,
  output logic                  busy,
  output logic                  done
);

  localparam int PMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int LEDS = 2**SYM_W;

  localparam logic [31:0]   TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [PW-1:0] ON_LAST   = PW'(ON_TICKS - 1);
  localparam logic [PW-1:0] OFF_LAST  = PW'(OFF_TICKS - 1);
  localparam logic [AW:0]   MAX_LEN   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   ONE_LEN   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ON    = 3'd2,
    S_OFF   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW:0]       len_q, len_d;
  logic [LEDS-1:0]   led_q, led_d;
  logic [31:0]       tick_q, tick_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic              tick_fire;
  logic [AW:0]       len_last;

  assign tick_fire = (tick_q == TICK_LAST);
  assign len_last  = len_q - ONE_LEN;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    led_d   = led_q;
    tick_d  = tick_q;
    phase_d = phase_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort && (len != '0)) begin
          len_d   = (len > MAX_LEN) ? MAX_LEN : len;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        led_d           = '0;
        led_d[sym_data] = 1'b1;
        tick_d          = '0;
        phase_d         = '0;
        state_d         = S_ON;
      end
      S_ON: begin
        if (tick_fire) begin
          tick_d = '0;
          if (phase_q == ON_LAST) begin
            led_d   = '0;
            phase_d = '0;
            state_d = S_OFF;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
      S_OFF: begin
        if (tick_fire) begin
          tick_d = '0;
          if (phase_q == OFF_LAST) begin
            phase_d = '0;
            // Compare at AW+1 bits so len = MAX_LEN terminates at idx = MAX_LEN-1.
            if ({1'b0, idx_q} == len_last) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + AW'(1);
              state_d = S_FETCH;
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every non-idle transition; idx is held so sym_addr stays put.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      led_d   = '0;
      tick_d  = '0;
      phase_d = '0;
    end
  end

  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      led_q   <= '0;
      tick_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
    end
  end

  assign sym_addr = idx_q;
  assign led      = led_q;
  assign busy     = (state_q == S_FETCH) || (state_q == S_ON) || (state_q == S_OFF);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_playback_ctrl.sv
// Bench for seq_playback_ctrl: a timeline model derives every output from the
// cycle offset since start acceptance, checked each cycle, plus literal pins.
module tb_seq_playback_ctrl;

  localparam int TD   = 4;
  localparam int ONT  = 2;
  localparam int OFFT = 1;
  localparam int AW   = 4;
  localparam int SW   = 2;
  localparam int P    = 1 + (ONT + OFFT) * TD;
  localparam int MAXL = 2**AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW:0]   len_i;
  logic [AW-1:0] sym_addr;
  logic [SW-1:0] sym_data;
  logic [3:0]    led;
  logic          busy;
  logic          done;

  logic [SW-1:0] mem [0:MAXL-1];

  int checks   = 0;
  int failures = 0;

  seq_playback_ctrl #(
    .TICK_DIV (TD),
    .ON_TICKS (ONT),
    .OFF_TICKS(OFFT),
    .AW       (AW),
    .SYM_W    (SW)
  ) dut (
    .cin     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .len     (len_i),
    .sym_addr(sym_addr),
    .sym_data(sym_data),
    .led     (led),
    .busy    (busy),
    .done    (done)
  );

  assign sym_data = mem[sym_addr];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // behavioural model: a run is described by its accept cycle and length only
  int          cyc = 0;
  bit          m_valid = 0;
  bit          m_act = 0;
  int          m_t0 = 0;
  int          m_len = 0;
  int          m_addr = 0;
  logic [3:0]  exp_led;
  logic        exp_busy;
  logic        exp_done;
  logic [3:0]  exp_addr;

  always @(posedge clk) begin
    int t, k, r, prev_t;
    cyc++;
    if (rst) begin
      m_act   = 0;
      m_addr  = 0;
      m_valid = 1;
    end else begin
      prev_t = (cyc - 1) - m_t0;
      if (m_act) begin
        if (abort || prev_t == 1 + m_len * P) m_act = 0;
      end else if (start && !abort && len_i != 0) begin
        m_act = 1;
        m_t0  = cyc - 1;
        m_len = (int'(len_i) > MAXL) ? MAXL : int'(len_i);
      end
    end
    if (m_act) begin
      t = cyc - m_t0;
      k = (t - 1) / P;
      if (k > m_len - 1) k = m_len - 1;
      r = (t - 1) % P;
      m_addr   = k;
      exp_busy = (t <= m_len * P);
      exp_done = (t == 1 + m_len * P);
      exp_led  = (exp_busy && r >= 1 && r <= ONT * TD) ? (4'b0001 << mem[k]) : 4'b0000;
    end else begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_led  = 4'b0000;
    end
    exp_addr = 4'(m_addr);
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_led",  {28'd0, led},      rst ? 32'd0 : {28'd0, exp_led});
      chk("cyc_busy", {31'd0, busy},     rst ? 32'd0 : {31'd0, exp_busy});
      chk("cyc_done", {31'd0, done},     rst ? 32'd0 : {31'd0, exp_done});
      chk("cyc_addr", {28'd0, sym_addr}, rst ? 32'd0 : {28'd0, exp_addr});
    end
  end

  // capture buffers for literal pins (index = cycle number after acceptance)
  logic [3:0] d_led  [0:255];
  logic [3:0] d_addr [0:255];
  logic       d_busy [0:255];
  logic       d_done [0:255];
  logic [3:0] m_led  [0:255];
  logic       m_done [0:255];

  task automatic launch(input int l);
    @(negedge clk);
    start = 1'b1;
    len_i = 5'(l);
  endtask

  task automatic capture(input int n, input bit hold, input int poke);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == poke) begin
        start = 1'b1;
        len_i = 5'd5;
      end else if (!hold) begin
        start = 1'b0;
      end
      d_led[i]  = led;
      d_addr[i] = sym_addr;
      d_busy[i] = busy;
      d_done[i] = done;
      m_led[i]  = exp_led;
      m_done[i] = exp_done;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || done) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  function automatic int count_done(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (d_done[i]) c++;
    return c;
  endfunction

  task automatic set_basic_pattern();
    mem[0] = 2'd2;
    mem[1] = 2'd0;
    mem[2] = 2'd3;
  endtask

  initial begin
    int nb, ns, w, l;
    rst = 1'b1; start = 1'b0; abort = 1'b0; len_i = '0;
    for (int j = 0; j < MAXL; j++) mem[j] = 2'(j);
    repeat (2) @(negedge clk);
    chk("reset_led",  {28'd0, led}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_addr", {28'd0, sym_addr}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic playback
    set_basic_pattern();
    launch(3);
    capture(45, 0, 0);
    chk("basic_led_c1",   {28'd0, d_led[1]},  32'h0);
    chk("basic_led_c2",   {28'd0, d_led[2]},  32'h4);
    chk("basic_led_c9",   {28'd0, d_led[9]},  32'h4);
    chk("basic_led_c10",  {28'd0, d_led[10]}, 32'h0);
    chk("basic_led_c15",  {28'd0, d_led[15]}, 32'h1);
    chk("basic_led_c22",  {28'd0, d_led[22]}, 32'h1);
    chk("basic_led_c28",  {28'd0, d_led[28]}, 32'h8);
    chk("basic_led_c35",  {28'd0, d_led[35]}, 32'h8);
    chk("basic_busy_c1",  {31'd0, d_busy[1]},  32'd1);
    chk("basic_busy_c39", {31'd0, d_busy[39]}, 32'd1);
    chk("basic_busy_c40", {31'd0, d_busy[40]}, 32'd0);
    chk("basic_done_c40", {31'd0, d_done[40]}, 32'd1);
    chk("basic_done_cnt", count_done(1, 45), 32'd1);
    chk("model_led_c2",   {28'd0, m_led[2]},  32'h4);
    chk("model_led_c15",  {28'd0, m_led[15]}, 32'h1);
    chk("model_led_c36",  {28'd0, m_led[36]}, 32'h0);
    chk("model_done_c40", {31'd0, m_done[40]}, 32'd1);
    drain();

    // zero length
    launch(0);
    capture(20, 0, 0);
    nb = 0;
    for (int i = 1; i <= 20; i++) if (d_busy[i] || d_done[i]) nb++;
    chk("len0_quiet", nb, 32'd0);

    // over-long length clamps to 16 symbols
    for (int j = 0; j < MAXL; j++) mem[j] = 2'($urandom_range(0, 3));
    launch(20);
    capture(215, 0, 0);
    ns = 0;
    for (int i = 2; i <= 215; i++) if (d_led[i] != 0 && d_led[i-1] == 0) ns++;
    chk("long_symbols",  ns, 32'd16);
    chk("long_done_209", {31'd0, d_done[209]}, 32'd1);
    chk("long_done_cnt", count_done(1, 215), 32'd1);
    chk("long_addr_end", {28'd0, d_addr[215]}, 32'd15);
    drain();

    // abort during second symbol's ON
    set_basic_pattern();
    launch(3);
    capture(16, 0, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_led",  {28'd0, led}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    capture(60, 0, 0);
    chk("abort_no_done", count_done(1, 60), 32'd0);

    // abort and start together in idle
    @(negedge clk);
    start = 1'b1; abort = 1'b1; len_i = 5'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_start_busy2", {31'd0, busy}, 32'd0);

    // start while busy is ignored
    launch(2);
    capture(35, 0, 20);
    chk("busy_start_done27", {31'd0, d_done[27]}, 32'd1);
    chk("busy_start_cnt",    count_done(1, 35), 32'd1);
    chk("busy_start_idle",   {31'd0, d_busy[30]}, 32'd0);
    drain();

    // asynchronous reset during ON of the second symbol
    set_basic_pattern();
    launch(3);
    capture(16, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("areset_led",  {28'd0, led}, 32'd0);
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_done", {31'd0, done}, 32'd0);
    chk("areset_addr", {28'd0, sym_addr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    launch(3);
    capture(3, 0, 0);
    chk("replay_addr_c1", {28'd0, d_addr[1]}, 32'd0);
    chk("replay_led_c2",  {28'd0, d_led[2]},  32'h4);
    drain();

    // back-to-back with start held high
    launch(1);
    capture(50, 1, 0);
    start = 1'b0;
    chk("b2b_done14",  {31'd0, d_done[14]}, 32'd1);
    chk("b2b_done29",  {31'd0, d_done[29]}, 32'd1);
    chk("b2b_done44",  {31'd0, d_done[44]}, 32'd1);
    chk("b2b_done_cnt", count_done(1, 50), 32'd3);
    drain();

    // randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      for (int j = 0; j < MAXL; j++) mem[j] = 2'($urandom_range(0, 3));
      l = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 6);
      launch(l);
      @(negedge clk);
      start = 1'b0;
      w = $urandom_range(10, 120);
      repeat (w) begin
        @(negedge clk);
        abort = ($urandom_range(0, 99) < 3);
        start = ($urandom_range(0, 99) < 4);
        len_i = 5'($urandom_range(0, 31));
      end
      abort = 1'b0;
      start = 1'b0;
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout t=%0t actual=running required=finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_playback_ctrl.md
# seq_playback_ctrl

Sequences playback of a stored colour pattern onto the game LEDs for the Sequence Memory Game. On `start` it steps through `len` symbols from pattern memory and lights each one for a fixed on-time followed by a dark gap. Both times are counted in slow ticks from an internal programmable clock divider. It raises a one-cycle `done` when the last gap ends, and the game FSM owns the start/abort handshake.

## Interface
Parameters:
- `TICK_DIV`, default 25000000: `cin` cycles per slow tick; must be ≥ 1. Benches use small values.
- `ON_TICKS`, default 2: ticks each symbol is lit; must be ≥ 1.
- `OFF_TICKS`, default 1: ticks of dark gap after each symbol; must be ≥ 1.
- `AW`, default 4: pattern address width. MAX_LEN = 2**AW.
- `SYM_W`, default 2: symbol width. LED count = 2**SYM_W.

Ports:
- `cin`, input, 1: clock, 50 MHz on the DE10-Lite.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request playback. Sampled only in IDLE.
- `abort`, input, 1: cancel playback immediately.
- `len`, input, AW+1: number of symbols to play. Captured when `start` is accepted.
- `sym_addr`, output, AW: pattern memory read address.
- `sym_data`, input, SYM_W: pattern memory data. Combinational read, valid in the same cycle as `sym_addr`.
- `led`, output, 2**SYM_W: one-hot LED drive, registered.
- `busy`, output, 1: high in FETCH, ON and OFF.
- `done`, output, 1: one-cycle pulse in DONE.

## Operation
States are IDLE, FETCH, ON, OFF and DONE.

- **IDLE**
  - `start`=1, `abort`=0, `len`≠0: capture `len`, clamped to MAX_LEN if larger. Clear `idx` to 0. Go to FETCH.
  - `len`=0: the start is ignored. No `busy`, no `done`.
- **FETCH** (exactly one cycle)
  - `sym_addr` = `idx`.
  - Latch `led` ← onehot(`sym_data`). Clear the tick and phase counters. Go to ON.
- **ON**
  - `led` holds the one-hot value.
  - The tick counter counts 0..TICK_DIV-1 and wraps to 0. A tick fires on the cycle the counter equals TICK_DIV-1.
  - The phase counter increments on each tick.
  - On the tick where phase = ON_TICKS-1: `led` ← 0, clear both counters, go to OFF.
- **OFF**
  - Same counting as ON.
  - On the tick where phase = OFF_TICKS-1:
    - If `idx` = `len`-1, go to DONE.
    - Otherwise `idx` ← `idx`+1 and go to FETCH.
- **DONE**: `done`=1 and `busy`=0 for one cycle, then go to IDLE.

Rules in all states:
- `abort`=1 in any non-IDLE state: go to IDLE on the next edge. `led` ← 0, no `done` pulse, counters cleared.
- In IDLE, `abort` wins over a simultaneous `start`.
- `start` is ignored in every state other than IDLE. Changes to `len` after capture have no effect.
- `sym_addr` holds `idx` in every state. It returns to 0 only on reset or on start acceptance.
- Width rules:
  - Tick counter is 32 bits.
  - Phase counter is wide enough for max(ON_TICKS, OFF_TICKS)-1.
  - `idx` is AW bits and never wraps, because it stops at `len`-1 ≤ MAX_LEN-1.
  - Comparison of `idx` with `len`-1 is done at AW+1 bits.

## Timing
- Reset is asynchronous. It forces IDLE and clears `led`, `busy`, `done`, `sym_addr`, `idx` and all counters to 0. Removing reset mid-playback resumes in IDLE.
- Cycle numbering: cycle 0 is the cycle where `start` is accepted.
  - Cycle 1 is FETCH and `busy` rises.
  - `led` is lit from cycle 2 for exactly ON_TICKS×TICK_DIV cycles.
  - `led` is then dark for OFF_TICKS×TICK_DIV cycles.
- Symbol period P = 1 + (ON_TICKS+OFF_TICKS)×TICK_DIV cycles.
- `done` is high at cycle 1 + `len`×P. `busy` is high for cycles 1 .. `len`×P.
- A new `start` can be accepted in the cycle after DONE, when the block is back in IDLE.
- Abort latency is one edge: `led` and `busy` are 0 on the cycle after `abort` is sampled high.

## Test plan
- **Basic playback.** TICK_DIV=4, ON=2, OFF=1, `len`=3, pattern {2,0,3}.
  - `led`=4'b0100 on cycles 2–9, 4'b0001 on cycles 15–22, 4'b1000 on cycles 28–35.
  - `done` pulse at cycle 40. `busy` high for cycles 1–39.
- **Zero length and over-long length.**
  - `len`=0 with `start`: `busy` and `done` stay 0.
  - `len`=20 with AW=4: exactly 16 symbols play, and `sym_addr` ends at 15.
- **Abort.**
  - `abort` during the second symbol's ON: `led`=0 and `busy`=0 on the next cycle, and `done` never rises.
  - `abort` and `start` high together in IDLE: the block stays in IDLE.
- **Start while busy.** Pulse `start` with `len`=5 mid-playback of `len`=2: playback ends after 2 symbols and `done` is at cycle 1+2P.
- **Asynchronous reset.** Assert `rst` between clock edges during ON: all outputs go to 0 immediately. After release, a fresh `start` replays from `sym_addr`=0.
- **Back-to-back runs.** `start` held high continuously with `len`=1: runs are accepted every P+2 cycles, and each produces exactly one `done` pulse.
